// File: rtl/closest_hit_pkg.sv
// Shared types and helpers for the closest-hit reduction and its downstream
// hit-point consumers: float word layout, ray/object records, FSM states and
// the candidate qualification test.
package closest_hit_pkg;

  localparam int FLOAT_W = 32;
  localparam int EXP_W   = 8;

  // 1e-3 as an IEEE-754 single: smallest t accepted, guards against a ray
  // re-hitting the surface it was spawned from.
  localparam logic [FLOAT_W-1:0] T_MIN_DEFAULT = 32'h3A83126F;

  typedef logic [FLOAT_W-1:0] float_t;

  typedef struct packed {
    logic [2:0][FLOAT_W-1:0] dir;
    logic [2:0][FLOAT_W-1:0] origin;
  } ray_t;

  typedef struct packed {
    logic [2:0][FLOAT_W-1:0] axis;
    logic [2:0][FLOAT_W-1:0] center;
  } obj_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SCAN,
    ST_EMIT_HIT,
    ST_EMIT_MISS
  } state_t;

  // A candidate is usable when the intersector flagged a hit and t is a
  // finite, non-negative float no smaller than t_min. Once sign and NaN/Inf
  // are excluded, float ordering equals unsigned integer ordering.
  function automatic logic float_qualify(input float_t t, input logic hit,
                                         input float_t t_min);
    logic exp_all_ones;
    exp_all_ones = (t[FLOAT_W-2 -: EXP_W] == {EXP_W{1'b1}});
    return hit && !t[FLOAT_W-1] && !exp_all_ones && (t >= t_min);
  endfunction

endpackage

// File: rtl/closest_hit_axis_hold_reg.sv
// Single-entry AXI-stream output register. Loaded once per result; valid
// drops after its own handshake, data is held stable while valid is high.
module axis_hold_reg #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         load,
  input  logic [W-1:0] din,
  output logic [W-1:0] tdata,
  output logic         tvalid,
  input  logic         tready
);

  // Capture on load, release valid when the consumer takes the beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tvalid <= 1'b0;
      tdata  <= '0;
    end else if (load) begin
      tvalid <= 1'b1;
      tdata  <= din;
    end else if (tvalid && tready) begin
      tvalid <= 1'b0;
    end
  end

endmodule

// File: rtl/closest_hit.sv
// Per-ray nearest-hit reduction. Latches one ray, scans its candidate stream
// keeping the smallest qualifying t, then emits either {t, object, ray} on
// three independent streams or the ray alone on the miss stream.
module closest_hit
  import closest_hit_pkg::*;
#(
  parameter int              SIZE  = FLOAT_W,
  parameter int              IDX_W = 8,
  parameter logic [SIZE-1:0] T_MIN = T_MIN_DEFAULT
) (
  input  logic                aclk,
  input  logic                areset,

  input  logic [6*SIZE-1:0]   ray_axis_tdata,
  input  logic                ray_axis_tvalid,
  output logic                ray_axis_tready,

  input  logic [SIZE-1:0]     cand_axis_tdata,
  input  logic                cand_axis_thit,
  input  logic [6*SIZE-1:0]   cand_axis_obj,
  input  logic                cand_axis_is_cylinder,
  input  logic                cand_axis_tlast,
  input  logic                cand_axis_tvalid,
  output logic                cand_axis_tready,

  output logic [SIZE-1:0]     t_axis_tdata,
  output logic                t_axis_tvalid,
  input  logic                t_axis_tready,

  output logic [6*SIZE-1:0]   obj_axis_tdata,
  output logic                obj_axis_is_cylinder,
  output logic [IDX_W-1:0]    obj_axis_index,
  output logic                obj_axis_tvalid,
  input  logic                obj_axis_tready,

  output logic [6*SIZE-1:0]   hitray_axis_tdata,
  output logic                hitray_axis_tvalid,
  input  logic                hitray_axis_tready,

  output logic [6*SIZE-1:0]   miss_axis_tdata,
  output logic                miss_axis_tvalid,
  input  logic                miss_axis_tready
);

  localparam int OBJ_HOLD_W = IDX_W + 1 + 6 * SIZE;

  state_t            state;
  state_t            next_state;
  logic              ray_rdy;
  logic              cand_rdy;

  ray_t              ray_reg;
  logic              best_valid;
  logic [SIZE-1:0]   best_t;
  obj_t              best_obj;
  logic              best_cyl;
  logic [IDX_W-1:0]  best_idx;
  logic [IDX_W-1:0]  idx_cnt;

  obj_t              cand_obj;
  logic              ray_fire;
  logic              cand_fire;
  logic              cand_ok;
  logic              cand_wins;
  logic              last_fire;

  logic              fin_valid;
  logic [SIZE-1:0]   fin_t;
  obj_t              fin_obj;
  logic              fin_cyl;
  logic [IDX_W-1:0]  fin_idx;

  logic              hit_load;
  logic              miss_load;
  logic              t_done;
  logic              obj_done;
  logic              hitray_done;
  logic [OBJ_HOLD_W-1:0] obj_hold_din;
  logic [OBJ_HOLD_W-1:0] obj_hold_q;

  assign cand_obj  = cand_axis_obj;
  assign ray_fire  = ray_axis_tvalid && ray_rdy;
  assign cand_fire = cand_axis_tvalid && cand_rdy;
  assign last_fire = cand_fire && cand_axis_tlast;

  // Qualified candidates compare as unsigned integers; strict less-than keeps
  // the earlier object on a tie.
  assign cand_ok   = float_qualify(cand_axis_tdata, cand_axis_thit, T_MIN);
  assign cand_wins = cand_ok && (!best_valid || (cand_axis_tdata < best_t));

  // Result including the current beat, so the tlast beat can still win.
  assign fin_valid = best_valid || cand_wins;
  assign fin_t     = cand_wins ? cand_axis_tdata       : best_t;
  assign fin_obj   = cand_wins ? cand_obj              : best_obj;
  assign fin_cyl   = cand_wins ? cand_axis_is_cylinder : best_cyl;
  assign fin_idx   = cand_wins ? idx_cnt               : best_idx;

  assign hit_load  = last_fire && fin_valid;
  assign miss_load = last_fire && !fin_valid;

  // A stream is finished once its valid is low or is being taken this cycle.
  assign t_done      = !t_axis_tvalid      || t_axis_tready;
  assign obj_done    = !obj_axis_tvalid    || obj_axis_tready;
  assign hitray_done = !hitray_axis_tvalid || hitray_axis_tready;

  // Next-state decode for the ray / scan / emit sequence.
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE:      if (ray_fire) next_state = ST_SCAN;
      ST_SCAN:      if (last_fire) next_state = fin_valid ? ST_EMIT_HIT : ST_EMIT_MISS;
      ST_EMIT_HIT:  if (t_done && obj_done && hitray_done) next_state = ST_IDLE;
      ST_EMIT_MISS: if (!miss_axis_tvalid || miss_axis_tready) next_state = ST_IDLE;
      default:      next_state = ST_IDLE;
    endcase
  end

  // State and registered readies; readies never follow downstream readies
  // combinationally and are held low while reset is asserted.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state    <= ST_IDLE;
      ray_rdy  <= 1'b0;
      cand_rdy <= 1'b0;
    end else begin
      state    <= next_state;
      ray_rdy  <= (next_state == ST_IDLE);
      cand_rdy <= (next_state == ST_SCAN);
    end
  end

  // Ray latch, running best candidate and saturating beat index.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      ray_reg    <= '0;
      best_valid <= 1'b0;
      best_t     <= '0;
      best_obj   <= '0;
      best_cyl   <= 1'b0;
      best_idx   <= '0;
      idx_cnt    <= '0;
    end else if (ray_fire) begin
      ray_reg    <= ray_axis_tdata;
      best_valid <= 1'b0;
      idx_cnt    <= '0;
    end else if (cand_fire) begin
      if (cand_wins) begin
        best_valid <= 1'b1;
        best_t     <= cand_axis_tdata;
        best_obj   <= cand_obj;
        best_cyl   <= cand_axis_is_cylinder;
        best_idx   <= idx_cnt;
      end
      if (idx_cnt != {IDX_W{1'b1}}) idx_cnt <= idx_cnt + 1'b1;
    end
  end

  assign ray_axis_tready  = ray_rdy;
  assign cand_axis_tready = cand_rdy;

  assign obj_hold_din = {fin_idx, fin_cyl, fin_obj};

  axis_hold_reg #(.W(SIZE)) u_t_hold (
    .clk    (aclk),
    .rst    (areset),
    .load   (hit_load),
    .din    (fin_t),
    .tdata  (t_axis_tdata),
    .tvalid (t_axis_tvalid),
    .tready (t_axis_tready)
  );

  axis_hold_reg #(.W(OBJ_HOLD_W)) u_obj_hold (
    .clk    (aclk),
    .rst    (areset),
    .load   (hit_load),
    .din    (obj_hold_din),
    .tdata  (obj_hold_q),
    .tvalid (obj_axis_tvalid),
    .tready (obj_axis_tready)
  );

  assign obj_axis_index       = obj_hold_q[OBJ_HOLD_W-1 -: IDX_W];
  assign obj_axis_is_cylinder = obj_hold_q[6*SIZE];
  assign obj_axis_tdata       = obj_hold_q[6*SIZE-1:0];

  axis_hold_reg #(.W(6*SIZE)) u_hitray_hold (
    .clk    (aclk),
    .rst    (areset),
    .load   (hit_load),
    .din    (ray_reg),
    .tdata  (hitray_axis_tdata),
    .tvalid (hitray_axis_tvalid),
    .tready (hitray_axis_tready)
  );

  axis_hold_reg #(.W(6*SIZE)) u_miss_hold (
    .clk    (aclk),
    .rst    (areset),
    .load   (miss_load),
    .din    (ray_reg),
    .tdata  (miss_axis_tdata),
    .tvalid (miss_axis_tvalid),
    .tready (miss_axis_tready)
  );

endmodule

// File: tb/tb_closest_hit.sv
// Directed and scoreboarded bench for closest_hit.
module tb_closest_hit;

  localparam int SIZE  = 32;
  localparam int IDX_W = 8;
  localparam int RW    = 6 * SIZE;
  localparam logic [31:0] TMIN = 32'h3A83126F;

  logic              aclk = 1'b0;
  logic              areset;
  logic [RW-1:0]     ray_axis_tdata;
  logic              ray_axis_tvalid;
  logic              ray_axis_tready;
  logic [SIZE-1:0]   cand_axis_tdata;
  logic              cand_axis_thit;
  logic [RW-1:0]     cand_axis_obj;
  logic              cand_axis_is_cylinder;
  logic              cand_axis_tlast;
  logic              cand_axis_tvalid;
  logic              cand_axis_tready;
  logic [SIZE-1:0]   t_axis_tdata;
  logic              t_axis_tvalid;
  logic              t_axis_tready;
  logic [RW-1:0]     obj_axis_tdata;
  logic              obj_axis_is_cylinder;
  logic [IDX_W-1:0]  obj_axis_index;
  logic              obj_axis_tvalid;
  logic              obj_axis_tready;
  logic [RW-1:0]     hitray_axis_tdata;
  logic              hitray_axis_tvalid;
  logic              hitray_axis_tready;
  logic [RW-1:0]     miss_axis_tdata;
  logic              miss_axis_tvalid;
  logic              miss_axis_tready;

  always #5 aclk = ~aclk;

  closest_hit #(.SIZE(SIZE), .IDX_W(IDX_W), .T_MIN(TMIN)) dut (
    .aclk                 (aclk),
    .areset               (areset),
    .ray_axis_tdata       (ray_axis_tdata),
    .ray_axis_tvalid      (ray_axis_tvalid),
    .ray_axis_tready      (ray_axis_tready),
    .cand_axis_tdata      (cand_axis_tdata),
    .cand_axis_thit       (cand_axis_thit),
    .cand_axis_obj        (cand_axis_obj),
    .cand_axis_is_cylinder(cand_axis_is_cylinder),
    .cand_axis_tlast      (cand_axis_tlast),
    .cand_axis_tvalid     (cand_axis_tvalid),
    .cand_axis_tready     (cand_axis_tready),
    .t_axis_tdata         (t_axis_tdata),
    .t_axis_tvalid        (t_axis_tvalid),
    .t_axis_tready        (t_axis_tready),
    .obj_axis_tdata       (obj_axis_tdata),
    .obj_axis_is_cylinder (obj_axis_is_cylinder),
    .obj_axis_index       (obj_axis_index),
    .obj_axis_tvalid      (obj_axis_tvalid),
    .obj_axis_tready      (obj_axis_tready),
    .hitray_axis_tdata    (hitray_axis_tdata),
    .hitray_axis_tvalid   (hitray_axis_tvalid),
    .hitray_axis_tready   (hitray_axis_tready),
    .miss_axis_tdata      (miss_axis_tdata),
    .miss_axis_tvalid     (miss_axis_tvalid),
    .miss_axis_tready     (miss_axis_tready)
  );

  int passes = 0;
  int fails  = 0;
  int cyc    = 0;

  logic [31:0]      tq[$];
  logic [RW-1:0]    oq[$];
  logic [IDX_W-1:0] iq[$];
  logic             cq[$];
  logic [RW-1:0]    hq[$];
  logic [RW-1:0]    mq[$];
  int               rq[$];

  always @(posedge aclk) cyc <= cyc + 1;

  // Output and ray handshakes, sampled mid-cycle.
  always @(negedge aclk) begin
    if (t_axis_tvalid && t_axis_tready) tq.push_back(t_axis_tdata);
    if (obj_axis_tvalid && obj_axis_tready) begin
      oq.push_back(obj_axis_tdata);
      iq.push_back(obj_axis_index);
      cq.push_back(obj_axis_is_cylinder);
    end
    if (hitray_axis_tvalid && hitray_axis_tready) hq.push_back(hitray_axis_tdata);
    if (miss_axis_tvalid && miss_axis_tready) mq.push_back(miss_axis_tdata);
    if (ray_axis_tvalid && ray_axis_tready) rq.push_back(cyc);
  end

  task automatic check(input string tag, input logic [RW-1:0] obs, input logic [RW-1:0] exp);
    assert (obs === exp) begin
      passes++;
    end else begin
      fails++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic clear_q();
    tq.delete(); oq.delete(); iq.delete(); cq.delete();
    hq.delete(); mq.delete(); rq.delete();
  endtask

  function automatic logic [RW-1:0] mk(input logic [31:0] b);
    return {b + 32'd5, b + 32'd4, b + 32'd3, b + 32'd2, b + 32'd1, b};
  endfunction

  function automatic logic [RW-1:0] rand_rec();
    return {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
  endfunction

  function automatic logic model_qual(input logic [31:0] t, input logic hit);
    return hit && !t[31] && (t[30:23] != 8'hFF) && (t >= TMIN);
  endfunction

  function automatic logic [31:0] rand_t(input logic [31:0] prev);
    case ($urandom_range(0, 7))
      0, 1, 2: return {1'b0, 8'($urandom_range(110, 140)), 23'($urandom)};
      3:       return {1'b1, 8'($urandom_range(110, 140)), 23'($urandom)};
      4:       return {1'b0, 8'hFF, 23'($urandom)};
      5:       return 32'h3A000000 + 32'($urandom_range(0, 255));
      6:       return prev;
      default: return TMIN;
    endcase
  endfunction

  task automatic send_ray(input logic [RW-1:0] r);
    int n = 0;
    ray_axis_tdata  = r;
    ray_axis_tvalid = 1'b1;
    while (!ray_axis_tready && n < 50) begin tick(); n++; end
    check("ray_accept", RW'(ray_axis_tready), RW'(1));
    tick();
    ray_axis_tvalid = 1'b0;
  endtask

  task automatic send_cand(input logic [31:0] t, input logic hit, input logic [RW-1:0] o,
                           input logic cyl, input logic last);
    int n = 0;
    cand_axis_tdata       = t;
    cand_axis_thit        = hit;
    cand_axis_obj         = o;
    cand_axis_is_cylinder = cyl;
    cand_axis_tlast       = last;
    cand_axis_tvalid      = 1'b1;
    while (!cand_axis_tready && n < 50) begin tick(); n++; end
    check("cand_accept", RW'(cand_axis_tready), RW'(1));
    tick();
    cand_axis_tvalid = 1'b0;
    cand_axis_tlast  = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (!ray_axis_tready && n < 100) begin tick(); n++; end
    check(tag, RW'(ray_axis_tready), RW'(1));
  endtask

  initial begin
    logic [RW-1:0]    r, o_hold;
    logic             stable;
    logic [31:0]      ts[4];
    logic             hs[4];
    logic [RW-1:0]    os[4];
    logic             cs[4];
    logic [31:0]      et[$];
    logic [RW-1:0]    eo[$];
    logic [IDX_W-1:0] ei[$];
    logic             ec[$];
    logic [RW-1:0]    eh[$];
    logic [RW-1:0]    em[$];
    logic             bv;
    logic [31:0]      bt;
    int               bi, bad, nmis;

    areset = 1'b1;
    ray_axis_tdata = '0; ray_axis_tvalid = 1'b0;
    cand_axis_tdata = '0; cand_axis_thit = 1'b0; cand_axis_obj = '0;
    cand_axis_is_cylinder = 1'b0; cand_axis_tlast = 1'b0; cand_axis_tvalid = 1'b0;
    t_axis_tready = 1'b1; obj_axis_tready = 1'b1;
    hitray_axis_tready = 1'b1; miss_axis_tready = 1'b1;

    // Reset state
    tick(); tick();
    check("rst_readies", RW'({ray_axis_tready, cand_axis_tready}), RW'(0));
    check("rst_valids", RW'({t_axis_tvalid, obj_axis_tvalid, hitray_axis_tvalid, miss_axis_tvalid}), RW'(0));
    check("rst_index", RW'(obj_axis_index), RW'(0));
    areset = 1'b0;
    tick();
    check("idle_ray_ready", RW'(ray_axis_tready), RW'(1));
    check("idle_cand_ready", RW'(cand_axis_tready), RW'(0));

    // Test 1: 5.0, 2.0 (cylinder), 7.0 -> 2.0 at index 1
    clear_q();
    send_ray(mk(32'h1000));
    send_cand(32'h40A00000, 1'b1, mk(32'hA000), 1'b0, 1'b0);
    send_cand(32'h40000000, 1'b1, mk(32'hB000), 1'b1, 1'b0);
    send_cand(32'h40E00000, 1'b1, mk(32'hC000), 1'b0, 1'b1);
    check("t1_first_emit_valids",
          RW'({t_axis_tvalid, obj_axis_tvalid, hitray_axis_tvalid, miss_axis_tvalid}), RW'(4'b1110));
    check("t1_emit_no_ray_ready", RW'(ray_axis_tready), RW'(0));
    wait_idle("t1_idle");
    check("t1_counts", RW'({tq.size(), oq.size(), hq.size(), mq.size()}), RW'({32'd1, 32'd1, 32'd1, 32'd0}));
    if (tq.size() == 1 && oq.size() == 1 && hq.size() == 1) begin
      check("t1_t", RW'(tq[0]), RW'(32'h40000000));
      check("t1_obj", oq[0], mk(32'hB000));
      check("t1_index", RW'(iq[0]), RW'(1));
      check("t1_cyl", RW'(cq[0]), RW'(1));
      check("t1_hitray", hq[0], mk(32'h1000));
    end

    // Test 2: tie keeps first; negative and sub-T_MIN rejected
    clear_q();
    send_ray(mk(32'h2000));
    send_cand(32'h40400000, 1'b1, mk(32'hA100), 1'b0, 1'b0);
    send_cand(32'h40400000, 1'b1, mk(32'hA200), 1'b1, 1'b0);
    send_cand(32'hBF800000, 1'b1, mk(32'hA300), 1'b0, 1'b0);
    send_cand(32'h3A03126F, 1'b1, mk(32'hA400), 1'b0, 1'b1);
    wait_idle("t2_idle");
    check("t2_counts", RW'({tq.size(), oq.size(), mq.size()}), RW'({32'd1, 32'd1, 32'd0}));
    if (tq.size() == 1 && oq.size() == 1) begin
      check("t2_t", RW'(tq[0]), RW'(32'h40400000));
      check("t2_index", RW'(iq[0]), RW'(0));
      check("t2_obj", oq[0], mk(32'hA100));
      check("t2_cyl", RW'(cq[0]), RW'(0));
    end

    // Test 3: no hits plus a NaN hit -> miss with the ray
    clear_q();
    send_ray(mk(32'h3000));
    send_cand(32'h3F800000, 1'b0, mk(32'hA500), 1'b0, 1'b0);
    send_cand(32'h40000000, 1'b0, mk(32'hA600), 1'b0, 1'b0);
    send_cand(32'h7FC00000, 1'b1, mk(32'hA700), 1'b0, 1'b1);
    check("t3_first_emit_valids",
          RW'({t_axis_tvalid, obj_axis_tvalid, hitray_axis_tvalid, miss_axis_tvalid}), RW'(4'b0001));
    check("t3_miss_data", miss_axis_tdata, mk(32'h3000));
    wait_idle("t3_idle");
    check("t3_counts", RW'({tq.size(), oq.size(), hq.size(), mq.size()}), RW'({32'd0, 32'd0, 32'd0, 32'd1}));

    // Test 4: obj stream stalled 10 cycles
    clear_q();
    obj_axis_tready = 1'b0;
    send_ray(mk(32'h4000));
    send_cand(32'h40800000, 1'b1, mk(32'hA800), 1'b0, 1'b0);
    send_cand(32'h3FC00000, 1'b1, mk(32'hA900), 1'b1, 1'b1);
    check("t4_first_emit_valids",
          RW'({t_axis_tvalid, obj_axis_tvalid, hitray_axis_tvalid}), RW'(3'b111));
    o_hold = obj_axis_tdata;
    tick();
    check("t4_after_partial",
          RW'({t_axis_tvalid, obj_axis_tvalid, hitray_axis_tvalid}), RW'(3'b010));
    stable = 1'b1;
    for (int i = 0; i < 9; i++) begin
      stable = stable && obj_axis_tvalid && (obj_axis_tdata === o_hold) && !ray_axis_tready
               && (obj_axis_index === 8'd1);
      tick();
    end
    check("t4_obj_stable", RW'(stable), RW'(1));
    check("t4_no_ray_ready_before", RW'(ray_axis_tready), RW'(0));
    obj_axis_tready = 1'b1;
    tick();
    check("t4_obj_done", RW'(obj_axis_tvalid), RW'(0));
    check("t4_ray_ready_after", RW'(ray_axis_tready), RW'(1));
    check("t4_counts", RW'({tq.size(), oq.size(), hq.size()}), RW'({32'd1, 32'd1, 32'd1}));
    if (tq.size() == 1 && oq.size() == 1) begin
      check("t4_t", RW'(tq[0]), RW'(32'h3FC00000));
      check("t4_obj", oq[0], mk(32'hA900));
    end

    // Test 5: reset mid-scan, then a clean single-beat ray
    send_ray(mk(32'h5000));
    send_cand(32'h3F000000, 1'b1, mk(32'hAA00), 1'b0, 1'b0);
    send_cand(32'h3F400000, 1'b1, mk(32'hAB00), 1'b0, 1'b0);
    areset = 1'b1;
    #1;
    check("t5_rst_immediate",
          RW'({ray_axis_tready, cand_axis_tready, t_axis_tvalid, obj_axis_tvalid,
               hitray_axis_tvalid, miss_axis_tvalid}), RW'(0));
    tick(); tick();
    check("t5_rst_held",
          RW'({ray_axis_tready, cand_axis_tready, t_axis_tvalid, miss_axis_tvalid}), RW'(0));
    areset = 1'b0;
    clear_q();
    wait_idle("t5_idle_after_rst");
    send_ray(mk(32'h5100));
    send_cand(32'h3F800000, 1'b1, mk(32'hAC00), 1'b0, 1'b1);
    wait_idle("t5_idle");
    check("t5_counts", RW'({tq.size(), oq.size(), hq.size(), mq.size()}), RW'({32'd1, 32'd1, 32'd1, 32'd0}));
    if (tq.size() == 1 && oq.size() == 1 && hq.size() == 1) begin
      check("t5_t", RW'(tq[0]), RW'(32'h3F800000));
      check("t5_index", RW'(iq[0]), RW'(0));
      check("t5_obj", oq[0], mk(32'hAC00));
      check("t5_hitray", hq[0], mk(32'h5100));
    end

    // Test 6: 1000 back-to-back random rays of 4 candidates
    clear_q();
    bt = 32'h40000000;
    for (int k = 0; k < 1000; k++) begin
      r = rand_rec();
      bv = 1'b0;
      bi = 0;
      for (int i = 0; i < 4; i++) begin
        ts[i] = rand_t(bt);
        hs[i] = ($urandom_range(0, 9) < 8);
        os[i] = rand_rec();
        cs[i] = 1'($urandom);
        if (model_qual(ts[i], hs[i]) && (!bv || ts[i] < bt)) begin
          bv = 1'b1; bt = ts[i]; bi = i;
        end
        if (!bv) bt = ts[i];
      end
      if (bv) begin
        et.push_back(bt); eo.push_back(os[bi]); ei.push_back(IDX_W'(bi));
        ec.push_back(cs[bi]); eh.push_back(r);
      end else begin
        em.push_back(r);
      end
      send_ray(r);
      for (int i = 0; i < 4; i++) send_cand(ts[i], hs[i], os[i], cs[i], (i == 3));
    end
    wait_idle("t6_idle");
    check("t6_hit_count", RW'({tq.size(), oq.size(), hq.size()}),
          RW'({32'(et.size()), 32'(et.size()), 32'(et.size())}));
    check("t6_miss_count", RW'(mq.size()), RW'(em.size()));
    nmis = 0;
    if (tq.size() == et.size() && oq.size() == et.size() && hq.size() == et.size()) begin
      for (int i = 0; i < et.size(); i++) begin
        if (tq[i] !== et[i] || oq[i] !== eo[i] || iq[i] !== ei[i] || cq[i] !== ec[i] || hq[i] !== eh[i])
          nmis++;
      end
    end
    check("t6_hit_data_mismatches", RW'(nmis), RW'(0));
    nmis = 0;
    if (mq.size() == em.size())
      for (int i = 0; i < em.size(); i++) if (mq[i] !== em[i]) nmis++;
    check("t6_miss_data_mismatches", RW'(nmis), RW'(0));
    check("t6_ray_count", RW'(rq.size()), RW'(1000));
    bad = 0;
    for (int i = 0; i + 1 < rq.size(); i++) if (rq[i+1] - rq[i] != 6) bad++;
    check("t6_period_not_6", RW'(bad), RW'(0));

    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end

endmodule
